// File: rtl/div_32bits_pkg.sv
// Shared definitions for the multi-cycle RV32M divider: op codes, FSM state
// encodings and the constants returned by the special cases.
package div_32bits_pkg;

    // funct3[1:0] of the M-extension divide group
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX,
        DONE = ST_DONE
    } div_state_e;

    // Architectural results for divide-by-zero and signed overflow
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/div_32bits_step.sv
// One restoring shift-subtract iteration. The trial subtract reuses the
// 32-bit adder form (a + ~b + 1); the 33rd bit is resolved from the adder
// carry and the bits shifted above bit 31.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             no_borrow;

    // Shift in the next dividend bit, subtract the divisor, keep the trial if it did not go negative
    always_comb begin
        shifted      = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        {carry, sum} = {1'b0, shifted[WIDTH-1:0]} + {1'b0, ~divisor_i} + {{WIDTH{1'b0}}, 1'b1};
        // Any bit at or above 2^32 in the shifted remainder guarantees it exceeds the divisor
        no_borrow    = rem_i[WIDTH] | shifted[WIDTH] | carry;
        rem_o        = no_borrow ? {~(shifted[WIDTH] ^ carry), sum} : shifted;
        quo_o        = {quo_i[WIDTH-2:0], no_borrow};
    end

endmodule

// File: rtl/div_32bits.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Signed operands are made
// positive at accept, 32 restoring iterations run in CALC, and FIX selects
// quotient or remainder and restores the sign. Divide-by-zero and signed
// overflow are answered directly at the accept edge.
module div_32bits
    import div_32bits_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    div_state_e       state_q, state_d;
    logic [5:0]       count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [1:0]       op_q, op_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept;
    logic             is_signed;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] fix_sel;
    logic             fix_neg;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            op_q      <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            op_q      <= op_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            result_q  <= result_d;
        end
    end

    // Next-state logic: iterate in CALC, sign-fix in FIX, accept new work in IDLE/DONE
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        op_d      = op_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        result_d  = result_q;

        is_signed = ~op[0];
        abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
        div_zero  = (b == '0);
        overflow  = is_signed && (a == INT_MIN) && (b == '1);
        accept    = start && ((state_q == IDLE) || (state_q == DONE));

        fix_sel   = op_q[1] ? rem_q[WIDTH-1:0] : quo_q;
        fix_neg   = op_q[1] ? r_neg_q : q_neg_q;

        case (state_q)
            IDLE: state_d = IDLE;
            CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = fix_neg ? -fix_sel : fix_sel;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new request overrides the default transitions of IDLE and DONE
        if (accept) begin
            op_d      = op;
            q_neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_d   = is_signed & a[WIDTH-1];
            rem_d     = '0;
            quo_d     = abs_a;
            divisor_d = abs_b;
            count_d   = '0;
            if (div_zero) begin
                result_d = op[1] ? a : DIV_ZERO_Q;
                state_d  = DONE;
            end else if (overflow) begin
                result_d = op[1] ? '0 : INT_MIN;
                state_d  = DONE;
            end else begin
                state_d  = CALC;
            end
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_32bits.sv
// Bench for div_32bits: directed cases for the RV32M corner cases and the
// handshake, then randomized operations checked against an arithmetic model.
module tb_div_32bits;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    div_32bits #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // RV32M semantics in plain arithmetic; lat is the cycle in which done appears
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, output int lat);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx  = x;
        sy  = y;
        lat = 34;
        if (y == 32'd0) begin
            lat = 1;
            return o[1] ? x : 32'hFFFF_FFFF;
        end
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            lat = 1;
            return o[1] ? 32'd0 : 32'h8000_0000;
        end
        if (o[0]) return o[1] ? (x % y) : (x / y);
        return o[1] ? 32'(sx % sy) : 32'(sx / sy);
    endfunction

    // Drive a request at the current (negedge) time and record its expectation
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int          l;
        logic [31:0] r;
        r = model(o, x, y, l);
        exp_q.push_back(r);
        lat_q.push_back(l);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Follow one operation to done; optionally poke start while busy; chain leaves
    // the bench at the done cycle so the caller can issue back-to-back
    task automatic wait_done(input string tag, input int poke_at, input bit chain);
        logic [31:0] er;
        int          el;
        int          cyc;
        int          busy_cnt;
        bit          got;
        er       = exp_q.pop_front();
        el       = lat_q.pop_front();
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            if (poke_at != 0 && cyc == poke_at) start = 1'b1;
            if (poke_at != 0 && cyc == poke_at + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
            if (cyc == 1 && el != 1) check({tag, "_done_low_c1"}, 32'(done), 32'd0);
        end
        check({tag, "_latency"}, 32'(cyc), 32'(el));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), (el == 1) ? 32'd0 : 32'd33);
        check({tag, "_result"}, result, er);
        if (!chain) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        bit prev_chain;
        bit chain;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;

        // Normal operations
        @(negedge clk); issue(2'b01, 32'd100, 32'd7);               wait_done("divu_100_7", 0, 1'b0);
        @(negedge clk); issue(2'b11, 32'd100, 32'd7);               wait_done("remu_100_7", 0, 1'b0);
        @(negedge clk); issue(2'b00, 32'hFFFF_FFF9, 32'd2);         wait_done("div_m7_2", 0, 1'b0);
        @(negedge clk); issue(2'b10, 32'hFFFF_FFF9, 32'd2);         wait_done("rem_m7_2", 0, 1'b0);
        @(negedge clk); issue(2'b01, 32'hFFFF_FFFF, 32'd1);         wait_done("divu_max_1", 0, 1'b0);

        // Special cases
        @(negedge clk); issue(2'b01, 32'd5, 32'd0);                 wait_done("divu_by0", 0, 1'b0);
        @(negedge clk); issue(2'b10, 32'hFFFF_FFFB, 32'd0);         wait_done("rem_by0", 0, 1'b0);
        @(negedge clk); issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", 0, 1'b0);
        @(negedge clk); issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("rem_ovf", 0, 1'b0);

        // Start while busy is ignored
        @(negedge clk); issue(2'b01, 32'd1000, 32'd10);             wait_done("poke_busy", 10, 1'b0);

        // Back-to-back through DONE
        @(negedge clk); issue(2'b01, 32'd77, 32'd7);                wait_done("b2b_first", 0, 1'b1);
        issue(2'b01, 32'd9, 32'd3);                                 wait_done("b2b_second", 0, 1'b1);
        issue(2'b01, 32'd5, 32'd0);                                 wait_done("b2b_special", 0, 1'b1);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2);                         wait_done("b2b_after_special", 0, 1'b0);

        // Randomized operations
        prev_chain = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!prev_chain) @(negedge clk);
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom; rb = 32'($urandom_range(1, 15)); end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            chain = (i != 23) && ($urandom_range(0, 1) == 1);
            issue(ro, ra, rb);
            wait_done($sformatf("rand%0d", i), 0, chain);
            prev_chain = chain;
        end

        // Asynchronous reset in the middle of a DIV
        @(negedge clk); issue(2'b01, 32'd100, 32'd7);               wait_done("pre_reset", 0, 1'b0);
        @(negedge clk); issue(2'b00, 32'h1234_5678, 32'h0000_0123);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("mid_calc_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", result, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_hold_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done), 32'd0);
        end
        issue(2'b01, 32'd20, 32'd4);                                wait_done("divu_after_rst", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
